// File: rtl/codeword_detector_if.sv
// Bus bundle for the serial code-word detector: the divided clock and serial
// data going in, and the strobe, match flag and counters coming back out.
interface codeword_detector_if #(
    parameter int CODE_LEN = 8
) ();

    localparam int BW = $clog2(CODE_LEN + 1);

    logic          clk_slow;
    logic          din;
    logic          enable;
    logic          strobe;
    logic          detected;
    logic [BW-1:0] bit_count;
    logic [7:0]    match_count;

    modport master (
        output clk_slow,
        output din,
        output enable,
        input  strobe,
        input  detected,
        input  bit_count,
        input  match_count
    );

    modport slave (
        input  clk_slow,
        input  din,
        input  enable,
        output strobe,
        output detected,
        output bit_count,
        output match_count
    );

endinterface

// File: rtl/codeword_detector.sv
// Serial code-word detector running on the fast clock cclk. The divided clock
// is sampled as data; each rising edge of it yields a one-cycle strobe that
// shifts in one serial bit. A full, non-overlapping match raises detected for
// HOLD_TICKS strobes and bumps a wrapping match counter.
module codeword_detector #(
    parameter int                  CODE_LEN   = 8,
    parameter logic [CODE_LEN-1:0] CODEWORD   = 8'b1011_0110,
    parameter int                  HOLD_TICKS = 4
) (
    input logic            cclk,
    input logic            rst,
    codeword_detector_if.slave bus
);

    localparam int BW = $clog2(CODE_LEN + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [BW-1:0] FULL_COUNT  = BW'(CODE_LEN);
    localparam logic [BW-1:0] MATCH_PRIOR = BW'(CODE_LEN - 1);
    localparam logic [HW-1:0] HOLD_LOAD   = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(1);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        MATCH
    } state_t;

    logic slow_meta;
    logic slow_sync;
    logic slow_hist;
    logic din_meta;
    logic din_sync;
    logic strobe_q;

    state_t              state_q;
    state_t              state_d;
    logic [CODE_LEN-1:0] shreg_q;
    logic [CODE_LEN-1:0] shreg_d;
    logic [BW-1:0]       bit_count_q;
    logic [BW-1:0]       bit_count_d;
    logic                detected_q;
    logic                detected_d;
    logic [HW-1:0]       hold_q;
    logic [HW-1:0]       hold_d;
    logic [7:0]          match_count_q;
    logic [7:0]          match_count_d;
    logic [CODE_LEN-1:0] shifted;

    // Two-flop synchronisers plus registered rising-edge detect; clk_slow
    // side resets high so a level already high at reset gives no strobe.
    always_ff @(posedge cclk) begin
        if (rst) begin
            slow_meta <= 1'b1;
            slow_sync <= 1'b1;
            slow_hist <= 1'b1;
            din_meta  <= 1'b0;
            din_sync  <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            slow_meta <= bus.clk_slow;
            slow_sync <= slow_meta;
            slow_hist <= slow_sync;
            din_meta  <= bus.din;
            din_sync  <= din_meta;
            strobe_q  <= slow_sync & ~slow_hist;
        end
    end

    // State and datapath registers; reset wins over any coincident strobe.
    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bit_count_q   <= '0;
            detected_q    <= 1'b0;
            hold_q        <= '0;
            match_count_q <= '0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_count_q   <= bit_count_d;
            detected_q    <= detected_d;
            hold_q        <= hold_d;
            match_count_q <= match_count_d;
        end
    end

    assign shifted = {shreg_q[CODE_LEN-2:0], din_sync};

    // Next-state logic: shift/match in SEARCH, hold countdown in MATCH,
    // and a dropped enable forcing IDLE regardless of any strobe.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_count_d   = bit_count_q;
        detected_d    = detected_q;
        hold_d        = hold_q;
        match_count_d = match_count_q;

        case (state_q)
            IDLE: begin
                shreg_d     = '0;
                bit_count_d = '0;
                detected_d  = 1'b0;
                hold_d      = '0;
                if (bus.enable) begin
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (strobe_q) begin
                    if ((shifted == CODEWORD) && (bit_count_q >= MATCH_PRIOR)) begin
                        state_d       = MATCH;
                        detected_d    = 1'b1;
                        hold_d        = HOLD_LOAD;
                        match_count_d = match_count_q + 8'd1;
                        shreg_d       = '0;
                        bit_count_d   = '0;
                    end else begin
                        shreg_d = shifted;
                        if (bit_count_q != FULL_COUNT) begin
                            bit_count_d = bit_count_q + BW'(1);
                        end
                    end
                end
            end
            MATCH: begin
                if (strobe_q) begin
                    if (hold_q <= HOLD_LAST) begin
                        hold_d     = '0;
                        detected_d = 1'b0;
                        state_d    = SEARCH;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!bus.enable) begin
            state_d     = IDLE;
            shreg_d     = '0;
            bit_count_d = '0;
            detected_d  = 1'b0;
            hold_d      = '0;
        end
    end

    assign bus.strobe      = strobe_q;
    assign bus.detected    = detected_q;
    assign bus.bit_count   = bit_count_q;
    assign bus.match_count = match_count_q;

endmodule
